// File: rtl/crc_frame_checker.sv
// CRC-16/CCITT frame checker: buffers payload into one of two ping-pong banks while the
// CRC is recomputed, then forwards only frames whose trailing CRC matches.
module crc_frame_checker #(
   parameter int PAYLOAD_BYTES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startin,
   input  logic             pushin,
   input  logic [7:0]       datain,
   output logic             pushout,
   output logic             startout,
   output logic [7:0]       dataout,
   output logic             chk_valid,
   output logic             chk_ok,
   output logic             abort,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PAYLOAD = 2'd1;
   localparam logic [1:0] S_CRC_HI  = 2'd2;
   localparam logic [1:0] S_CRC_LO  = 2'd3;

   function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [7:0] d);
      logic [15:0] c;
      logic        fb;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         fb = c[15] ^ d[7-i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   logic [7:0]       bank_q [2][PAYLOAD_BYTES];
   logic [1:0]       st_q, st_d;
   logic [15:0]      crc_q, crc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       rx_hi_q, rx_hi_d;
   logic             fill_bank_q, fill_bank_d;
   logic             chk_valid_q, chk_valid_d, chk_ok_q, chk_ok_d, abort_q, abort_d;
   logic [CNT_W-1:0] good_q, good_d, bad_q, bad_d;
   logic [1:0]       ready_q, ready_d;
   logic             old_q, old_d;
   logic             drain_act_q, drain_act_d, drain_bank_q, drain_bank_d;
   logic [IDX_W-1:0] drain_idx_q, drain_idx_d;
   logic             pushout_q, pushout_d, startout_q, startout_d;
   logic [7:0]       dataout_q, dataout_d;

   logic             wr_en_s, wr_bank_s, set_ready_s, good_inc_s, bad_inc_s;
   logic [IDX_W-1:0] wr_idx_s;
   logic [1:0]       busy_s;
   logic             fill_sel_s, pick_s;

   // A bank is busy while it holds a verified frame or is being drained.
   always_comb begin
      busy_s[0]  = ready_q[0] | (drain_act_q & ~drain_bank_q);
      busy_s[1]  = ready_q[1] | (drain_act_q & drain_bank_q);
      fill_sel_s = busy_s[0] ? 1'b1 : (busy_s[1] ? 1'b0 : ~fill_bank_q);
      pick_s     = (ready_q[0] & ready_q[1]) ? old_q : ready_q[1];
   end

   // Write FSM: collects payload and CRC bytes and decides pass, fail or abort.
   always_comb begin
      st_d        = st_q;
      crc_d       = crc_q;
      idx_d       = idx_q;
      rx_hi_d     = rx_hi_q;
      fill_bank_d = fill_bank_q;
      chk_valid_d = 1'b0;
      chk_ok_d    = 1'b0;
      abort_d     = 1'b0;
      good_inc_s  = 1'b0;
      bad_inc_s   = 1'b0;
      set_ready_s = 1'b0;
      wr_en_s     = 1'b0;
      wr_bank_s   = fill_bank_q;
      wr_idx_s    = idx_q;
      if (pushin && startin) begin
         if (st_q != S_IDLE) begin
            abort_d   = 1'b1;
            bad_inc_s = 1'b1;
         end else begin
            fill_bank_d = fill_sel_s;
         end
         wr_en_s   = 1'b1;
         wr_bank_s = fill_bank_d;
         wr_idx_s  = '0;
         crc_d     = crc_step(16'hFFFF, datain);
         idx_d     = ONE_IDX;
         st_d      = (PAYLOAD_BYTES == 1) ? S_CRC_HI : S_PAYLOAD;
      end else if (pushin) begin
         case (st_q)
            S_IDLE: begin
               st_d = S_IDLE;
            end
            S_PAYLOAD: begin
               wr_en_s = 1'b1;
               crc_d   = crc_step(crc_q, datain);
               if (idx_q == LAST_IDX) begin
                  st_d = S_CRC_HI;
               end else begin
                  idx_d = idx_q + ONE_IDX;
               end
            end
            S_CRC_HI: begin
               rx_hi_d = datain;
               st_d    = S_CRC_LO;
            end
            S_CRC_LO: begin
               chk_valid_d = 1'b1;
               st_d        = S_IDLE;
               if ({rx_hi_q, datain} == crc_q) begin
                  chk_ok_d    = 1'b1;
                  good_inc_s  = 1'b1;
                  set_ready_s = 1'b1;
               end else begin
                  bad_inc_s = 1'b1;
               end
            end
            default: begin
               st_d = S_IDLE;
            end
         endcase
      end else begin
         st_d = st_q;
      end
   end

   // Saturating frame counters.
   always_comb begin
      good_d = good_q;
      bad_d  = bad_q;
      if (good_inc_s && (good_q != {CNT_W{1'b1}})) begin
         good_d = good_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         good_d = good_q;
      end
      if (bad_inc_s && (bad_q != {CNT_W{1'b1}})) begin
         bad_d = bad_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         bad_d = bad_q;
      end
   end

   // Drain FSM: streams the oldest verified bank out, freeing it with its last byte.
   always_comb begin
      ready_d      = ready_q;
      old_d        = old_q;
      drain_act_d  = drain_act_q;
      drain_bank_d = drain_bank_q;
      drain_idx_d  = drain_idx_q;
      pushout_d    = 1'b0;
      startout_d   = 1'b0;
      dataout_d    = 8'h00;
      if (drain_act_q) begin
         pushout_d = 1'b1;
         dataout_d = bank_q[drain_bank_q][drain_idx_q];
         if (drain_idx_q == LAST_IDX) begin
            drain_act_d           = 1'b0;
            ready_d[drain_bank_q] = 1'b0;
         end else begin
            drain_idx_d = drain_idx_q + ONE_IDX;
         end
      end else if (ready_q != 2'b00) begin
         pushout_d    = 1'b1;
         startout_d   = 1'b1;
         dataout_d    = bank_q[pick_s][0];
         drain_bank_d = pick_s;
         if (PAYLOAD_BYTES == 1) begin
            ready_d[pick_s] = 1'b0;
         end else begin
            drain_act_d = 1'b1;
            drain_idx_d = ONE_IDX;
         end
      end else begin
         drain_act_d = 1'b0;
      end
      if (set_ready_s) begin
         ready_d[fill_bank_q] = 1'b1;
         old_d = ready_q[~fill_bank_q] ? ~fill_bank_q : fill_bank_q;
      end else begin
         old_d = old_q;
      end
   end

   // Payload storage; contents are only ever read behind a ready flag, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         bank_q[wr_bank_s][wr_idx_s] <= datain;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q         <= S_IDLE;
         crc_q        <= 16'hFFFF;
         idx_q        <= '0;
         rx_hi_q      <= 8'h00;
         fill_bank_q  <= 1'b1;
         chk_valid_q  <= 1'b0;
         chk_ok_q     <= 1'b0;
         abort_q      <= 1'b0;
         good_q       <= '0;
         bad_q        <= '0;
         ready_q      <= 2'b00;
         old_q        <= 1'b0;
         drain_act_q  <= 1'b0;
         drain_bank_q <= 1'b0;
         drain_idx_q  <= '0;
         pushout_q    <= 1'b0;
         startout_q   <= 1'b0;
         dataout_q    <= 8'h00;
      end else begin
         st_q         <= st_d;
         crc_q        <= crc_d;
         idx_q        <= idx_d;
         rx_hi_q      <= rx_hi_d;
         fill_bank_q  <= fill_bank_d;
         chk_valid_q  <= chk_valid_d;
         chk_ok_q     <= chk_ok_d;
         abort_q      <= abort_d;
         good_q       <= good_d;
         bad_q        <= bad_d;
         ready_q      <= ready_d;
         old_q        <= old_d;
         drain_act_q  <= drain_act_d;
         drain_bank_q <= drain_bank_d;
         drain_idx_q  <= drain_idx_d;
         pushout_q    <= pushout_d;
         startout_q   <= startout_d;
         dataout_q    <= dataout_d;
      end
   end

   assign pushout   = pushout_q;
   assign startout  = startout_q;
   assign dataout   = dataout_q;
   assign chk_valid = chk_valid_q;
   assign chk_ok    = chk_ok_q;
   assign abort     = abort_q;
   assign good_cnt  = good_q;
   assign bad_cnt   = bad_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Scoreboard bench for crc_frame_checker: two instances (4-byte/4-bit counters and
// 9-byte/16-bit counters) driven with directed and random frames against a frame-level model.
module tb_crc_frame_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [2];
   logic       startin [2];
   logic       pushin [2];
   logic [7:0] datain [2];
   logic       pushout [2];
   logic       startout [2];
   logic [7:0] dataout [2];
   logic       chk_valid [2];
   logic       chk_ok [2];
   logic       abort_o [2];
   logic [3:0]  good0, bad0;
   logic [15:0] good1, bad1;
   logic [15:0] gcnt [2];
   logic [15:0] bcnt [2];

   crc_frame_checker #(.PAYLOAD_BYTES(4), .CNT_W(4)) dut0 (
      .clk(clk), .reset(rst[0]), .startin(startin[0]), .pushin(pushin[0]), .datain(datain[0]),
      .pushout(pushout[0]), .startout(startout[0]), .dataout(dataout[0]),
      .chk_valid(chk_valid[0]), .chk_ok(chk_ok[0]), .abort(abort_o[0]),
      .good_cnt(good0), .bad_cnt(bad0));

   crc_frame_checker #(.PAYLOAD_BYTES(9), .CNT_W(16)) dut9 (
      .clk(clk), .reset(rst[1]), .startin(startin[1]), .pushin(pushin[1]), .datain(datain[1]),
      .pushout(pushout[1]), .startout(startout[1]), .dataout(dataout[1]),
      .chk_valid(chk_valid[1]), .chk_ok(chk_ok[1]), .abort(abort_o[1]),
      .good_cnt(good1), .bad_cnt(bad1));

   always_comb begin
      gcnt[0] = {12'h000, good0};
      bcnt[0] = {12'h000, bad0};
      gcnt[1] = good1;
      bcnt[1] = bad1;
   end

   int pb [2]   = '{4, 9};
   int cmax [2] = '{15, 65535};

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   logic [7:0] cur_q [2][$];
   bit         in_frame [2];
   logic [8:0] exp_out [2][$];
   bit         exp_chk [2][$];
   int         exp_abort [2];
   int         good_m [2];
   int         bad_m [2];
   int         crc_lo_cyc [2];
   int         last_chk [2];
   int         last_push [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[inst%0d] t=%0t: got %0h expected %0h", name, k, $time, act, exp);
      end
   endtask

   // CRC as the remainder of a long division of the augmented bit stream,
   // with the 0xFFFF preset folded into the leading 16 bits.
   function automatic logic [15:0] ref_crc(input logic [7:0] m[$], input int n);
      bit          b[$];
      logic [16:0] r;
      for (int i = 0; i < n; i++)
         for (int j = 7; j >= 0; j--) b.push_back(m[i][j]);
      for (int i = 0; i < 16; i++) b.push_back(1'b0);
      for (int i = 0; i < 16; i++) b[i] = ~b[i];
      r = 17'h0;
      foreach (b[i]) begin
         r = {r[15:0], b[i]};
         if (r[16]) r = r ^ 17'h11021;
      end
      return r[15:0];
   endfunction

   task automatic bump(input int k, input bit good);
      if (good) begin
         if (good_m[k] < cmax[k]) good_m[k]++;
      end else begin
         if (bad_m[k] < cmax[k]) bad_m[k]++;
      end
   endtask

   task automatic model_accept(input int k, input bit st, input logic [7:0] d);
      logic [15:0] rx;
      if (st) begin
         if (in_frame[k]) begin
            exp_abort[k]++;
            bump(k, 1'b0);
         end
         cur_q[k].delete();
         cur_q[k].push_back(d);
         in_frame[k] = 1'b1;
      end else if (in_frame[k]) begin
         cur_q[k].push_back(d);
      end else begin
         return;
      end
      if (cur_q[k].size() == pb[k] + 2) begin
         rx = {cur_q[k][pb[k]], cur_q[k][pb[k]+1]};
         crc_lo_cyc[k] = cyc;
         if (ref_crc(cur_q[k], pb[k]) == rx) begin
            bump(k, 1'b1);
            exp_chk[k].push_back(1'b1);
            for (int i = 0; i < pb[k]; i++) exp_out[k].push_back({(i == 0), cur_q[k][i]});
         end else begin
            bump(k, 1'b0);
            exp_chk[k].push_back(1'b0);
         end
         in_frame[k] = 1'b0;
      end
   endtask

   task automatic send(input int k, input bit st, input logic [7:0] d);
      model_accept(k, st, d);
      startin[k] = st;
      pushin[k]  = 1'b1;
      datain[k]  = d;
      @(posedge clk);
      #1;
      startin[k] = 1'b0;
      pushin[k]  = 1'b0;
      datain[k]  = 8'h00;
   endtask

   task automatic send_list(input int k, input logic [7:0] q[$]);
      foreach (q[i]) send(k, (i == 0), q[i]);
   endtask

   task automatic send_frame(input int k, input bit corrupt);
      logic [7:0]  q[$];
      logic [15:0] c;
      for (int i = 0; i < pb[k]; i++) q.push_back(8'($urandom_range(0, 255)));
      c = ref_crc(q, pb[k]);
      if (corrupt) c = c ^ (16'h0001 << $urandom_range(0, 15));
      q.push_back(c[15:8]);
      q.push_back(c[7:0]);
      send_list(k, q);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input int k);
      chk("good_cnt", k, 32'(gcnt[k]), 32'(good_m[k]));
      chk("bad_cnt", k, 32'(bcnt[k]), 32'(bad_m[k]));
   endtask

   task automatic do_reset(input int k);
      rst[k] = 1'b1;
      @(posedge clk);
      #1;
      rst[k] = 1'b0;
      exp_out[k].delete();
      exp_chk[k].delete();
      cur_q[k].delete();
      exp_abort[k] = 0;
      in_frame[k]  = 1'b0;
      good_m[k]    = 0;
      bad_m[k]     = 0;
      chk("rst_pushout", k, 32'(pushout[k]), 32'd0);
      chk("rst_startout", k, 32'(startout[k]), 32'd0);
      chk("rst_dataout", k, 32'(dataout[k]), 32'd0);
      chk("rst_chk_valid", k, 32'(chk_valid[k]), 32'd0);
      chk("rst_abort", k, 32'(abort_o[k]), 32'd0);
      check_counts(k);
   endtask

   // Monitor: pops expectations whenever an instance presents an output.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (pushout[k] === 1'b1) begin
            if (exp_out[k].size() == 0) begin
               chk("unexpected_pushout", k, {23'h0, startout[k], dataout[k]}, 32'h1FF00);
            end else begin
               chk("pushout_data", k, {23'h0, startout[k], dataout[k]}, 32'(exp_out[k].pop_front()));
               if (startout[k]) chk("first_out_latency", k, 32'(cyc), 32'(last_chk[k] + 1));
               else chk("out_contiguous", k, 32'(cyc), 32'(last_push[k] + 1));
            end
            last_push[k] = cyc;
         end
         if (chk_valid[k] === 1'b1) begin
            chk("chk_valid_latency", k, 32'(cyc), 32'(crc_lo_cyc[k] + 1));
            if (exp_chk[k].size() == 0) chk("unexpected_chk_valid", k, 32'(chk_ok[k]), 32'h2);
            else chk("chk_ok", k, 32'(chk_ok[k]), 32'(exp_chk[k].pop_front()));
            if (chk_ok[k]) last_chk[k] = cyc;
         end
         if (abort_o[k] === 1'b1) begin
            chk("abort_expected", k, 32'(exp_abort[k] > 0), 32'd1);
            if (exp_abort[k] > 0) exp_abort[k]--;
         end
      end
   end

   initial begin
      logic [7:0] q[$];
      int k;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; startin[i] = 1'b0; pushin[i] = 1'b0; datain[i] = 8'h00;
         last_chk[i] = -10; last_push[i] = -10; crc_lo_cyc[i] = -10;
      end
      idle(2);
      do_reset(0);
      do_reset(1);

      // Check-value frame "123456789" with good and with corrupted CRC.
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
      send_list(1, q);
      idle(16);
      check_counts(1);
      q[10] = 8'hB0;
      send_list(1, q);
      idle(16);
      check_counts(1);

      // Three back-to-back frames.
      for (int i = 0; i < 3; i++) send_frame(0, 1'b0);
      idle(10);
      check_counts(0);

      // Truncated frame followed by a good one.
      send(0, 1'b1, 8'hA5);
      send(0, 1'b0, 8'h5A);
      send_frame(0, 1'b0);
      idle(10);
      check_counts(0);

      // Stray bytes in idle, then reset in the middle of a drain.
      for (int i = 0; i < 3; i++) send(0, 1'b0, 8'($urandom_range(0, 255)));
      idle(4);
      send_frame(0, 1'b0);
      idle(2);
      do_reset(0);
      idle(8);
      send_frame(0, 1'b0);
      idle(10);
      check_counts(0);

      // Random mix of good, corrupted, truncated frames and stray bytes.
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 1);
         case ($urandom_range(0, 9))
            0, 1: send_frame(k, 1'b1);
            2: begin
               send(k, 1'b1, 8'($urandom_range(0, 255)));
               repeat ($urandom_range(0, pb[k])) send(k, 1'b0, 8'($urandom_range(0, 255)));
               send_frame(k, 1'b0);
            end
            default: send_frame(k, 1'b0);
         endcase
         if ($urandom_range(0, 3) == 0) send(k, 1'b0, 8'($urandom_range(0, 255)));
         idle($urandom_range(0, 3));
      end
      idle(16);
      check_counts(0);
      check_counts(1);

      // Bad-frame counter saturation on the 4-bit instance.
      do_reset(0);
      for (int i = 0; i < 15; i++) send_frame(0, 1'b1);
      idle(4);
      chk("bad_cnt_full", 0, 32'(bcnt[0]), 32'h0000000F);
      send_frame(0, 1'b1);
      idle(4);
      chk("bad_cnt_saturated", 0, 32'(bcnt[0]), 32'h0000000F);
      check_counts(0);

      idle(4);
      for (int i = 0; i < 2; i++) begin
         chk("leftover_out", i, 32'(exp_out[i].size()), 32'd0);
         chk("leftover_chk", i, 32'(exp_chk[i].size()), 32'd0);
         chk("leftover_abort", i, 32'(exp_abort[i]), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
